// File: rtl/xm23_pkg.sv
// Shared definitions for the XM23 interrupt controller: config map, register
// field positions, request encoding and FSM states.
package xm23_pkg;

  localparam logic [3:0] CFG_PEND  = 4'd8;
  localparam logic [3:0] CFG_SWSET = 4'd9;

  localparam int CTRL_EN_BIT  = 7;
  localparam int CTRL_PRI_MSB = 2;
  localparam int CTRL_PRI_LSB = 0;

  localparam int REQ_VALID_BIT = 7;
  localparam int REQ_PRI_MSB   = 6;
  localparam int REQ_PRI_LSB   = 4;
  localparam int REQ_VECT_MSB  = 3;
  localparam int REQ_VECT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACK     = 2'd2
  } pic_state_e;

  // Vector numbers are 4 bits and wrap modulo 16.
  function automatic logic [3:0] vect_of(input int base, input logic [2:0] idx);
    return 4'(base + int'(idx));
  endfunction

  function automatic logic [7:0] make_req(input logic [2:0] pri, input logic [3:0] vect);
    logic [7:0] r;
    r = '0;
    r[REQ_VALID_BIT]             = 1'b1;
    r[REQ_PRI_MSB:REQ_PRI_LSB]   = pri;
    r[REQ_VECT_MSB:REQ_VECT_LSB] = vect;
    return r;
  endfunction

  function automatic logic [7:0] make_ctrl(input logic en, input logic [2:0] pri);
    logic [7:0] r;
    r = '0;
    r[CTRL_EN_BIT]               = en;
    r[CTRL_PRI_MSB:CTRL_PRI_LSB] = pri;
    return r;
  endfunction

endpackage

// File: rtl/xm23_pic_if.sv
// Device-side and CPU-side signals of the interrupt controller; the master is
// the surrounding system (decoder, devices, CPU), the slave is the PIC.
interface xm23_pic_if #(
  parameter int NUM_SRC = 8
);
  logic [NUM_SRC-1:0] irq;
  logic [2:0]         cpu_pri;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [7:0]         cfg_wdata;
  logic [7:0]         cfg_rdata;
  logic [7:0]         pic_req;
  logic               pic_read;

  modport master (
    output irq, cpu_pri, cfg_we, cfg_addr, cfg_wdata, pic_read,
    input  cfg_rdata, pic_req
  );

  modport slave (
    input  irq, cpu_pri, cfg_we, cfg_addr, cfg_wdata, pic_read,
    output cfg_rdata, pic_req
  );
endinterface

// File: rtl/pic_sync_edge.sv
// Multi-flop synchronizer for one asynchronous irq pin followed by a
// rising-edge detector on the synchronized value.
module pic_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/xm23_pic.sv
// XM23 programmable interrupt controller: latches device edges as pending,
// arbitrates by priority against the CPU priority and presents one request.
module xm23_pic
  import xm23_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int VECT_BASE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst_n,
  xm23_pic_if.slave bus
);

  logic [NUM_SRC-1:0] rise_vec;
  logic [NUM_SRC-1:0] en;
  logic [2:0]         pri [NUM_SRC];
  logic [NUM_SRC-1:0] pending, pending_n;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] ctrl_wr, dis_mask, set_mask, clr_mask, retire_mask;
  logic               pend_wr, swset_wr;

  pic_state_e         state_q, state_n;
  logic [2:0]         idx_q, idx_n;
  logic [7:0]         req_q, req_n;
  logic [7:0]         rdata_q, rdata_n;

  logic               any_elig;
  logic [2:0]         win_idx;
  logic [2:0]         win_pri;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (bus.irq[g]),
      .rise (rise_vec[g])
    );
  end

  // ---------------------------------------------------------------- config decode
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    pend_wr  = bus.cfg_we && (bus.cfg_addr == CFG_PEND);
    swset_wr = bus.cfg_we && (bus.cfg_addr == CFG_SWSET);
    ctrl_wr  = '0;
    dis_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ctrl_wr[i]  = bus.cfg_we && (bus.cfg_addr == 4'(i));
      dis_mask[i] = ctrl_wr[i] && !bus.cfg_wdata[CTRL_EN_BIT];
    end
  end

  // NOTE: the CTRL array is reset explicitly; it is a handful of flops and
  // software relies on reading zeros after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= '0;
      for (int i = 0; i < NUM_SRC; i++) pri[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ctrl_wr[i]) begin
          en[i]  <= bus.cfg_wdata[CTRL_EN_BIT];
          pri[i] <= bus.cfg_wdata[CTRL_PRI_MSB:CTRL_PRI_LSB];
        end
      end
    end
  end

  // ---------------------------------------------------------------- pending
  // A set beats a clear on the same source; disabling beats both.
  always_comb begin
    set_mask  = (rise_vec | (swset_wr ? bus.cfg_wdata[NUM_SRC-1:0] : '0)) & en;
    clr_mask  = (pend_wr ? bus.cfg_wdata[NUM_SRC-1:0] : '0) | retire_mask;
    pending_n = ((pending & ~clr_mask) | set_mask) & ~dis_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_n;
  end

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    elig     = '0;
    any_elig = 1'b0;
    win_idx  = '0;
    win_pri  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = pending[i] && en[i] && (pri[i] > bus.cpu_pri);
      // Strict compare keeps the lowest index on a priority tie.
      if (elig[i] && (!any_elig || (pri[i] > win_pri))) begin
        any_elig = 1'b1;
        win_idx  = 3'(i);
        win_pri  = pri[i];
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      req_q   <= req_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE:    if (any_elig) state_n = ST_PRESENT;
      ST_PRESENT: begin
        if (bus.pic_read)      state_n = ST_ACK;
        else if (!elig[idx_q]) state_n = ST_IDLE;
      end
      ST_ACK:     state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_n       = idx_q;
    req_n       = '0;
    retire_mask = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          idx_n = win_idx;
          req_n = make_req(win_pri, vect_of(VECT_BASE, win_idx));
        end
      end
      ST_PRESENT: begin
        // The presented priority stays latched even if CTRL is rewritten.
        if (bus.pic_read)      retire_mask[idx_q] = 1'b1;
        else if (elig[idx_q])  req_n = req_q;
      end
      default: req_n = '0;
    endcase
  end

  // ---------------------------------------------------------------- readback
  always_comb begin
    rdata_n = '0;
    if (int'(bus.cfg_addr) < NUM_SRC)
      rdata_n = make_ctrl(en[bus.cfg_addr[2:0]], pri[bus.cfg_addr[2:0]]);
    else if (bus.cfg_addr == CFG_PEND)
      rdata_n = 8'(pending);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_n;
  end

  assign bus.pic_req   = req_q;
  assign bus.cfg_rdata = rdata_q;

endmodule

// File: tb/tb_xm23_pic.sv
// Bench for xm23_pic: register vectors from a table, interrupt sequences
// checked against a queue of expected requests.
module tb_xm23_pic;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  xm23_pic_if #(.NUM_SRC(8)) bus ();

  xm23_pic #(.NUM_SRC(8), .VECT_BASE(8), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    cycle();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] addr, output logic [7:0] data);
    bus.cfg_addr = addr;
    cycle();
    data = bus.cfg_rdata;
  endtask

  task automatic sb_check(input string name);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no expected entry, got %02h", name, bus.pic_req);
    end else begin
      check(name, bus.pic_req, exp_q.pop_front());
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.pic_req[7] && n < 20) begin
      cycle();
      n++;
    end
    if (!bus.pic_req[7]) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout, pic_req %02h", name, bus.pic_req);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      sb_check(name);
    end
  endtask

  task automatic ack(input string name);
    bus.pic_read = 1'b1;
    cycle();
    bus.pic_read = 1'b0;
    check({name, "_drop"}, bus.pic_req, 8'h00);
    cycle();
    check({name, "_gap"}, bus.pic_req, 8'h00);
  endtask

  vec_t       vecs[12];
  logic [7:0] rd;

  initial begin
    bus.irq       = '0;
    bus.cpu_pri   = 3'd3;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.pic_read  = 1'b0;

    // ------------------------------------------------ reset state
    #12;
    check("rst_req", bus.pic_req, 8'h00);
    check("rst_rdata", bus.cfg_rdata, 8'h00);
    cycle();
    rst_n = 1'b1;
    cycle();

    // ------------------------------------------------ register table
    vecs[0]  = '{1'b1, 4'd2,  8'h85, 8'h85};
    vecs[1]  = '{1'b1, 4'd1,  8'h84, 8'h84};
    vecs[2]  = '{1'b1, 4'd6,  8'h84, 8'h84};
    vecs[3]  = '{1'b1, 4'd4,  8'h86, 8'h86};
    vecs[4]  = '{1'b1, 4'd3,  8'hFF, 8'h87};
    vecs[5]  = '{1'b1, 4'd5,  8'h85, 8'h85};
    vecs[6]  = '{1'b1, 4'd0,  8'h82, 8'h82};
    vecs[7]  = '{1'b1, 4'd7,  8'h07, 8'h07};
    vecs[8]  = '{1'b1, 4'd10, 8'hFF, 8'h00};
    vecs[9]  = '{1'b0, 4'd9,  8'h00, 8'h00};
    vecs[10] = '{1'b0, 4'd8,  8'h00, 8'h00};
    vecs[11] = '{1'b0, 4'd15, 8'h00, 8'h00};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) cfg_write(vecs[i].addr, vecs[i].wdata);
      cfg_read(vecs[i].addr, rd);
      check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
    end

    // ------------------------------------------------ single source, exact latency
    bus.cfg_addr = 4'd8;
    cycle();
    bus.irq[2] = 1'b1;
    exp_q.push_back(8'hDA);
    repeat (3) cycle();
    check("t1_not_yet", bus.pic_req, 8'h00);
    check("t1_pend_not_yet", bus.cfg_rdata, 8'h00);
    cycle();
    check("t1_pend", bus.cfg_rdata, 8'h04);
    sb_check("t1_req");
    repeat (3) cycle();
    check("t1_hold", bus.pic_req, 8'hDA);
    ack("t1_ack");
    check("t1_pend_clr", bus.cfg_rdata, 8'h00);
    bus.irq[2] = 1'b0;

    // ------------------------------------------------ priority and tie order
    bus.irq[1] = 1'b1;
    bus.irq[4] = 1'b1;
    bus.irq[6] = 1'b1;
    exp_q.push_back(8'hEC);
    exp_q.push_back(8'hC9);
    exp_q.push_back(8'hCE);
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("t2_req%0d", k));
      ack($sformatf("t2_ack%0d", k));
    end
    bus.irq = '0;

    // ------------------------------------------------ cpu priority masking
    bus.cpu_pri = 3'd2;
    bus.irq[0]  = 1'b1;
    repeat (6) cycle();
    check("t3_masked", bus.pic_req, 8'h00);
    bus.cpu_pri = 3'd1;
    exp_q.push_back(8'hA8);
    cycle();
    sb_check("t3_unmasked");
    ack("t3_ack");
    bus.irq[0]  = 1'b0;
    bus.cpu_pri = 3'd3;

    // ------------------------------------------------ software set on a disabled source
    cfg_write(4'd9, 8'h80);
    cfg_read(4'd8, rd);
    check("t4_swset_dis", rd, 8'h00);

    // ------------------------------------------------ withdraw by PEND clear
    exp_q.push_back(8'hFB);
    cfg_write(4'd9, 8'h08);
    wait_req("t4_req");
    cfg_write(4'd8, 8'h08);
    cycle();
    check("t4_withdraw", bus.pic_req, 8'h00);
    cfg_read(4'd8, rd);
    check("t4_pend", rd, 8'h00);
    repeat (4) cycle();
    check("t4_idle", bus.pic_req, 8'h00);

    // ------------------------------------------------ edge coincident with retire
    bus.irq[5] = 1'b1;
    exp_q.push_back(8'hDD);
    wait_req("t5_first");
    bus.irq[5] = 1'b0;
    repeat (4) cycle();
    bus.cfg_addr = 4'd8;
    bus.irq[5]   = 1'b1;
    repeat (2) cycle();
    bus.pic_read = 1'b1;
    cycle();
    bus.pic_read = 1'b0;
    check("t5_drop", bus.pic_req, 8'h00);
    exp_q.push_back(8'hDD);
    cycle();
    check("t5_pend_kept", bus.cfg_rdata, 8'h20);
    check("t5_gap", bus.pic_req, 8'h00);
    cycle();
    sb_check("t5_represent");
    ack("t5_ack");
    bus.irq[5] = 1'b0;

    // ------------------------------------------------ async reset mid-PRESENT
    exp_q.push_back(8'hDA);
    cfg_write(4'd9, 8'h04);
    wait_req("t6_req");
    bus.cfg_addr = 4'd2;
    cycle();
    check("t6_rdata_pre", bus.cfg_rdata, 8'h85);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", bus.pic_req, 8'h00);
    check("t6_rst_rdata", bus.cfg_rdata, 8'h00);
    cycle();
    rst_n = 1'b1;
    for (int a = 0; a <= 8; a++) begin
      cfg_read(4'(a), rd);
      check($sformatf("t6_reg%0d", a), rd, 8'h00);
    end
    check("t6_req_idle", bus.pic_req, 8'h00);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drained: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
